// File: rtl/cu_fsm.sv
// Multicycle control sequencer: IF/ID/ALU/MEM/RB stepping with fetch handshake,
// memory timeout, interrupt acknowledge, halt and retired-instruction counter.
// Optional: define CU_FAST_PATH_EN to route non-memory instructions ALU -> RB.
module cu_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             ins_valid,
  input  logic             mem_ready,
  input  logic             int_ack,
  output logic             IF_en,
  output logic             ID_en,
  output logic             ALU_en,
  output logic             MEM_en,
  output logic             RB_BR_en,
  output logic             reg_read,
  output logic             reg_write,
  output logic [4:0]       alu_opcode,
  output logic [2:0]       branch_opcode,
  output logic [1:0]       mem_read,
  output logic [1:0]       mem_write,
  output logic [1:0]       RB_mux_opcode,
  output logic             interrupt,
  output logic             illegal,
  output logic             bus_error,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_ALU, S_MEM, S_RB, S_INT, S_HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_ir;
  logic [7:0]       r_wait;
  logic             r_if_en, r_id_en, r_alu_en, r_mem_en, r_rb_en;
  logic             r_reg_read, r_reg_write;
  logic [4:0]       r_alu_op;
  logic [2:0]       r_br_op;
  logic [1:0]       r_mem_read, r_mem_write, r_rb_mux;
  logic             r_interrupt, r_illegal, r_bus_error, r_halted;
  logic [CNT_W-1:0] r_count;

  logic       w_hlt, w_mtc, w_imm, w_beq, w_blt, w_branch;
  logic       w_load, w_store, w_mem, w_alu_cls, w_invalid, w_writes;
  logic       w_skip_mem, w_timeout, w_retire;
  logic [1:0] w_acc, w_rb_mux;
  logic [4:0] w_alu_op;
  logic [2:0] w_br_op;

  // Decode always looks at ir, so opcode activity outside IF has no effect.
  always_comb begin
    w_hlt     = (r_ir == 6'b000000);
    w_mtc     = (r_ir == 6'b100000);
    w_imm     = (r_ir == 6'b010000) || (r_ir == 6'b010001);
    w_beq     = (r_ir == 6'b011110);
    w_blt     = (r_ir == 6'b011111);
    w_branch  = (r_ir[5:2] == 4'b0111);
    w_load    = (r_ir == 6'b011000) || (r_ir == 6'b011010);
    w_store   = (r_ir == 6'b011001) || (r_ir == 6'b011011);
    w_mem     = w_load || w_store;
    w_alu_cls = (r_ir[5:3] < 3'b011) && !w_hlt && !w_imm;
    w_invalid = !(w_hlt || w_mtc || w_imm || w_branch || w_mem || w_alu_cls) ||
                (r_ir == 6'b111111);
    w_writes  = w_load || w_imm || w_alu_cls;
    w_acc     = r_ir[1] ? 2'b01 : 2'b11;

    w_rb_mux = 2'b00;
    if (w_load)         w_rb_mux = 2'b01;
    else if (w_imm)     w_rb_mux = 2'b11;
    else if (w_alu_cls) w_rb_mux = 2'b10;

    w_alu_op = 5'b00000;
    if (w_beq)          w_alu_op = 5'b00010;
    else if (w_blt)     w_alu_op = 5'b01111;
    else if (w_mem)     w_alu_op = 5'b10010;
    else if (w_alu_cls) w_alu_op = r_ir[4:0];

    w_br_op = 3'b011;
    if (w_hlt)          w_br_op = 3'b000;
    else if (w_branch)  w_br_op = {1'b1, r_ir[1:0]};

`ifdef CU_FAST_PATH_EN
    w_skip_mem = !w_mem;
`else
    w_skip_mem = 1'b0;
`endif

    // Ready on the last allowed wait cycle takes precedence over the timeout.
    w_timeout = w_mem && !mem_ready && (r_wait == WAIT_LAST);

    w_next = r_state;
    case (r_state)
      S_IF:    if (ins_valid) w_next = S_ID;
      S_ID: begin
        if (w_invalid)  w_next = S_IF;
        else if (w_mtc) w_next = S_INT;
        else            w_next = S_ALU;
      end
      S_ALU: begin
        if (w_hlt)           w_next = S_HALT;
        else if (w_skip_mem) w_next = S_RB;
        else                 w_next = S_MEM;
      end
      S_MEM: begin
        if (!w_mem || mem_ready) w_next = S_RB;
        else if (w_timeout)      w_next = S_IF;
      end
      S_RB:    w_next = S_IF;
      S_INT:   if (int_ack) w_next = S_IF;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase

    w_retire = (r_state == S_RB) || ((r_state == S_INT) && int_ack) ||
               ((r_state == S_ALU) && w_hlt);
  end

  // Outputs are registered on the edge that enters a state, so they describe
  // the state currently held; the entry-to-RB and entry-to-IF blocks at the
  // end override the per-state assignments made on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IF;
      r_ir        <= '0;
      r_wait      <= '0;
      r_if_en     <= 1'b1;
      r_id_en     <= 1'b0;
      r_alu_en    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_rb_en     <= 1'b0;
      r_reg_read  <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_op    <= '0;
      r_br_op     <= 3'b011;
      r_mem_read  <= '0;
      r_mem_write <= '0;
      r_rb_mux    <= '0;
      r_interrupt <= 1'b0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
      r_halted    <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_if_en     <= (w_next == S_IF);
      r_id_en     <= (w_next == S_ID);
      r_alu_en    <= (w_next == S_ALU);
      r_mem_en    <= (w_next == S_MEM);
      r_rb_en     <= (w_next == S_RB);
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
      if (w_retire) r_count <= r_count + CNT_W'(1);

      case (r_state)
        S_IF: if (ins_valid) r_ir <= opcode;
        S_ID: begin
          if (w_invalid) begin
            r_illegal <= 1'b1;
          end else if (w_mtc) begin
            r_interrupt <= 1'b1;
          end else begin
            r_reg_read <= !w_hlt;
            r_alu_op   <= w_alu_op;
            r_br_op    <= w_br_op;
          end
        end
        S_ALU: begin
          if (w_hlt) begin
            r_halted <= 1'b1;
          end else if (!w_skip_mem) begin
            r_wait      <= '0;
            r_mem_read  <= w_load  ? w_acc : 2'b00;
            r_mem_write <= w_store ? w_acc : 2'b00;
          end
        end
        S_MEM: begin
          if (w_timeout)                  r_bus_error <= 1'b1;
          else if (w_mem && !mem_ready)   r_wait <= r_wait + 8'd1;
        end
        default: ;
      endcase

      if ((w_next == S_RB) && (r_state != S_RB)) begin
        r_mem_read  <= '0;
        r_mem_write <= '0;
        if (w_writes) begin
          r_reg_read  <= 1'b0;
          r_reg_write <= 1'b1;
          r_rb_mux    <= w_rb_mux;
        end
      end

      if ((w_next == S_IF) && (r_state != S_IF)) begin
        r_reg_read  <= 1'b0;
        r_reg_write <= 1'b0;
        r_alu_op    <= '0;
        r_br_op     <= 3'b011;
        r_mem_read  <= '0;
        r_mem_write <= '0;
        r_rb_mux    <= '0;
        r_interrupt <= 1'b0;
      end
    end
  end

  assign IF_en         = r_if_en;
  assign ID_en         = r_id_en;
  assign ALU_en        = r_alu_en;
  assign MEM_en        = r_mem_en;
  assign RB_BR_en      = r_rb_en;
  assign reg_read      = r_reg_read;
  assign reg_write     = r_reg_write;
  assign alu_opcode    = r_alu_op;
  assign branch_opcode = r_br_op;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign RB_mux_opcode = r_rb_mux;
  assign interrupt     = r_interrupt;
  assign illegal       = r_illegal;
  assign bus_error     = r_bus_error;
  assign halted        = r_halted;
  assign instr_count   = r_count;

endmodule

// File: tb/tb_cu_fsm.sv
// Randomized bench for cu_fsm: an instruction-level model expands each opcode
// into its expected per-cycle output trace, compared cycle by cycle.
module tb_cu_fsm;

  localparam int MAXW = 15;
  localparam int CW   = 3;
`ifdef CU_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam int P_IF = 0, P_FETCH = 1, P_ID = 2, P_ALU = 3;
  localparam int P_MEM = 4, P_RB = 5, P_INT = 6, P_HALT = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          ins_valid, mem_ready, int_ack;
  logic          IF_en, ID_en, ALU_en, MEM_en, RB_BR_en;
  logic          reg_read, reg_write;
  logic [4:0]    alu_opcode;
  logic [2:0]    branch_opcode;
  logic [1:0]    mem_read, mem_write, RB_mux_opcode;
  logic          interrupt, illegal, bus_error, halted;
  logic [CW-1:0] instr_count;

  cu_fsm #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ins_valid(ins_valid),
    .mem_ready(mem_ready), .int_ack(int_ack),
    .IF_en(IF_en), .ID_en(ID_en), .ALU_en(ALU_en), .MEM_en(MEM_en),
    .RB_BR_en(RB_BR_en), .reg_read(reg_read), .reg_write(reg_write),
    .alu_opcode(alu_opcode), .branch_opcode(branch_opcode),
    .mem_read(mem_read), .mem_write(mem_write), .RB_mux_opcode(RB_mux_opcode),
    .interrupt(interrupt), .illegal(illegal), .bus_error(bus_error),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ph;
    logic [4:0]  en;
    logic        rr, rw;
    logic [4:0]  alu;
    logic [2:0]  br;
    logic [1:0]  mr, mw, rbm;
    logic        intr, ill, berr, hlt;
    int unsigned cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_cnt;
  logic        m_ill, m_berr;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [24:0] obs;
  assign obs = {IF_en, ID_en, ALU_en, MEM_en, RB_BR_en, reg_read, reg_write,
                alu_opcode, branch_opcode, mem_read, mem_write, RB_mux_opcode,
                interrupt, illegal, bus_error, halted};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input exp_t e);
    return {39'd0, e.en, e.rr, e.rw, e.alu, e.br, e.mr, e.mw, e.rbm,
            e.intr, e.ill, e.berr, e.hlt};
  endfunction

  function automatic exp_t init_exp(input int ph, input logic [4:0] en);
    exp_t e;
    e.ph = ph; e.en = en; e.rr = 1'b0; e.rw = 1'b0; e.alu = 5'd0; e.br = 3'b011;
    e.mr = 2'b00; e.mw = 2'b00; e.rbm = 2'b00;
    e.intr = 1'b0; e.ill = 1'b0; e.berr = 1'b0; e.hlt = 1'b0; e.cnt = 0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Expected trace of one instruction, from its first IF cycle up to the
  // cycle before the next IF (HALT: 'extra'+1 cycles in HALT).
  task automatic build(input logic [5:0] op, input int rdy, input int extra, input int idle);
    exp_t e;
    int   n;
    bit   is_hlt, is_mtc, is_imm, is_beq, is_blt, is_br, is_ld, is_st, is_alu, is_bad;
    is_hlt = (op == 6'd0);
    is_mtc = (op == 6'd32);
    is_imm = (op == 6'd16) || (op == 6'd17);
    is_beq = (op == 6'd30);
    is_blt = (op == 6'd31);
    is_br  = (op >= 6'd28) && (op <= 6'd31);
    is_ld  = (op == 6'd24) || (op == 6'd26);
    is_st  = (op == 6'd25) || (op == 6'd27);
    is_alu = (op < 6'd24) && !is_hlt && !is_imm;
    is_bad = !(is_hlt || is_mtc || is_imm || is_br || is_ld || is_st || is_alu);
    exp_q.delete();
    for (int i = 0; i <= idle; i++) begin
      e = init_exp((i == idle) ? P_FETCH : P_IF, 5'b10000);
      e.ill  = (i == 0) && m_ill;
      e.berr = (i == 0) && m_berr;
      push(e);
    end
    m_ill = 1'b0; m_berr = 1'b0;
    push(init_exp(P_ID, 5'b01000));
    if (is_bad) begin
      m_ill = 1'b1;
      return;
    end
    if (is_mtc) begin
      e = init_exp(P_INT, 5'b00000);
      e.intr = 1'b1;
      for (int j = 0; j <= extra; j++) push(e);
      m_cnt++;
      return;
    end
    e = init_exp(P_ALU, 5'b00100);
    e.rr  = !is_hlt;
    e.alu = is_beq ? 5'd2 : is_blt ? 5'd15 : (is_ld || is_st) ? 5'd18 :
            is_alu ? op[4:0] : 5'd0;
    e.br  = is_hlt ? 3'b000 : is_br ? {1'b1, op[1:0]} : 3'b011;
    push(e);
    if (is_hlt) begin
      m_cnt++;
      e.ph = P_HALT; e.en = 5'b00000; e.hlt = 1'b1;
      for (int j = 0; j <= extra; j++) push(e);
      return;
    end
    e.ph = P_MEM; e.en = 5'b00010;
    if (is_ld || is_st) begin
      n = (rdy < MAXW) ? rdy + 1 : MAXW;
      if (is_ld) e.mr = (op == 6'd24) ? 2'b11 : 2'b01;
      else       e.mw = (op == 6'd25) ? 2'b11 : 2'b01;
      for (int j = 0; j < n; j++) push(e);
      if (rdy >= MAXW) begin
        m_berr = 1'b1;
        return;
      end
    end else if (!FAST) begin
      push(e);
    end
    e.ph = P_RB; e.en = 5'b00001; e.mr = 2'b00; e.mw = 2'b00;
    if (is_ld || is_imm || is_alu) begin
      e.rr = 1'b0; e.rw = 1'b1;
      e.rbm = is_ld ? 2'b01 : is_imm ? 2'b11 : 2'b10;
    end
    push(e);
    m_cnt++;
  endtask

  // Called at the negedge following a rising edge taken with rst=1.
  task automatic reset_check(input string tag);
    check({tag, ".outs"}, obs, pack(init_exp(P_IF, 5'b10000)));
    check({tag, ".cnt"}, instr_count, 0);
    m_cnt = 0; m_ill = 1'b0; m_berr = 1'b0;
    rst = 1'b0; ins_valid = 1'b0; mem_ready = 1'b0; int_ack = 1'b0;
  endtask

  // abort >= 0: assert rst in that trace cycle instead of continuing.
  task automatic run(input string name, input logic [5:0] op, input int rdy,
                     input int extra, input int idle, input int abort);
    int jm, ji, ab;
    exp_t e;
    build(op, rdy, extra, idle);
    ab = abort;
    if (op == 6'd0 && ab < 0) ab = exp_q.size() - 1;
    jm = 0; ji = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      e = exp_q[i];
      check($sformatf("%s.c%0d", name, i), obs, pack(e));
      check($sformatf("%s.c%0d.cnt", name, i), instr_count, e.cnt % (1 << CW));
      opcode    = (e.ph == P_FETCH) ? op : 6'($urandom);
      ins_valid = (e.ph == P_FETCH) ? 1'b1 : (e.ph == P_IF) ? 1'b0 : 1'($urandom);
      mem_ready = (e.ph == P_MEM) ? (jm == rdy) : 1'($urandom);
      int_ack   = (e.ph == P_INT) ? (ji == extra) : 1'($urandom);
      if (e.ph == P_MEM) jm++;
      if (e.ph == P_INT) ji++;
      if (i == ab) begin
        rst = 1'b1;
        @(negedge clk);
        reset_check({name, ".rst"});
        return;
      end
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 15))
      0:       return 6'b100000;
      1:       return 6'b010000;
      2:       return 6'b010001;
      3:       return 6'b011100;
      4:       return 6'b011101;
      5:       return 6'b011110;
      6:       return 6'b011111;
      7:       return 6'b011000;
      8:       return 6'b011001;
      9:       return 6'b011010;
      10:      return 6'b011011;
      11:      return 6'b000000;
      12:      return 6'b111111;
      13:      return 6'($urandom_range(1, 23));
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int rdy, abort;
    logic [5:0] op;
    rst = 1'b1; opcode = '0; ins_valid = 1'b0; mem_ready = 1'b0; int_ack = 1'b0;
    m_cnt = 0; m_ill = 1'b0; m_berr = 1'b0;
    repeat (2) @(negedge clk);
    reset_check("reset");

    run("add",       6'b000001, 0,        0, 0, -1);
    run("lw_wait3",  6'b011000, 3,        0, 1, -1);
    run("sb_tmo",    6'b011011, MAXW + 5, 0, 0, -1);
    run("blt",       6'b011111, 0,        0, 0, -1);
    run("mtc",       6'b100000, 0,        3, 0, -1);
    run("inv",       6'b111111, 0,        0, 0, -1);
    run("hlt",       6'b000000, 0,        3, 0, -1);
    run("sw_last",   6'b011001, MAXW - 1, 0, 0, -1);
    run("lb_tmo",    6'b011010, MAXW,     0, 2, -1);
    run("ldi",       6'b010000, 0,        0, 0, -1);
    run("lw_rstmem", 6'b011000, 10,       0, 0, 5);
    run("mtc_rst",   6'b100000, 0,        6, 0, 4);

    for (int k = 0; k < 60; k++) begin
      op    = pick_op();
      rdy   = ($urandom_range(0, 3) == 0) ? $urandom_range(MAXW - 1, MAXW + 1)
                                          : $urandom_range(0, 3);
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
      run($sformatf("rnd%0d", k), op, rdy, $urandom_range(0, 4),
          $urandom_range(0, 2), abort);
    end
    run("tail", 6'b000111, 0, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
